decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Next-generation decode stage: a DEPTH-entry instruction queue with valid/ready handshakes on both sides.
- Decodes the head entry into RV32I fields, the immediate and an illegal-instruction flag.
- Sits between fetch and execute. Decouples fetch from execute back-pressure without dropping or duplicating instructions.
- Flush empties the queue in one cycle.

Parameters:
- DWIDTH, 32, instruction/data width.
- AWIDTH, 32, PC width.
- DEPTH, 2, queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush_i  input  1  discard all queued and incoming instructions.
- in_valid_i  input  1  fetch offers pc_i/insn_i.
- in_ready_o  output  1  queue can accept.
- pc_i  input  AWIDTH  fetched PC.
- insn_i  input  DWIDTH  fetched instruction.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  execute consumes head.
- pc_o  output  AWIDTH  head PC.
- insn_o  output  DWIDTH  head instruction, or INSN_NOP when empty.
- opcode_o  output  7  insn_o[6:0].
- rd_o  output  5  insn_o[11:7].
- funct3_o  output  3  insn_o[14:12].
- rs1_o  output  5  insn_o[19:15].
- rs2_o  output  5  insn_o[24:20].
- shamt_o  output  5  insn_o[24:20].
- funct7_o  output  7  insn_o[31:25].
- imm_o  output  DWIDTH  sign-extended immediate for opcode_o.
- illegal_o  output  1  head is not a legal RV32I encoding; only meaningful when out_valid_o=1.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Read/write pointers and count cleared to 0.
  - Every entry: pc=IMEM_BASE_ADDR, insn=INSN_NOP.
  - Resulting outputs: out_valid_o=0, in_ready_o=1, insn_o=INSN_NOP, pc_o=IMEM_BASE_ADDR, illegal_o=0, imm_o=0.
  - Reset mid-transfer discards everything; no partial state survives.
- Push: in_valid_i & in_ready_o & !flush_i. Entry written at wr_ptr on the rising edge; wr_ptr increments modulo DEPTH.
- Pop: out_valid_o & out_ready_i & !flush_i. rd_ptr increments modulo DEPTH.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; count tracks fullness.
- Ready/valid derivation:
  - in_ready_o = (count != DEPTH), derived from registered state only; no combinational path from out_ready_i.
  - out_valid_o = (count != 0).
- Full + pop in the same cycle: push is still refused that cycle (in_ready_o=0); the freed slot is visible next cycle.
- Push + pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- Push into an empty queue: the entry appears at the head the next cycle (latency 1); no bypass.
- Flush:
  - Synchronous and highest priority: next cycle count=0 and rd_ptr=wr_ptr.
  - A same-cycle push is dropped; a same-cycle pop is not counted as consumed.
  - Entry storage keeps its old contents.
- Head fields: decoded combinationally from the head entry.
- Empty queue outputs:
  - insn_o forced to INSN_NOP, so decoded fields are NOP fields.
  - pc_o shows the head slot's stored pc.
- Immediate: imm_o from an igen instance driven by the head instruction; widths identical to igen.
- Illegal-instruction rules (combinational, on head insn). illegal_o=1 when any of:
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM};
  - BRANCH with funct3 in {010, 011};
  - LOAD with funct3 in {011, 110, 111};
  - STORE with funct3 > 010;
  - JALR with funct3 != 000;
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7=0100000 and funct3 not in {000, 101};
  - OP_IMM shifts: funct3=001 with funct7!=0; funct3=101 with funct7 not in {0000000, 0100000}.
- illegal_o is gated by out_valid_o.

Optional Feature:
- Macro: DECODE_QUEUE_PERF_EN.
- When defined, two extra outputs are added:
  - decoded_cnt_o, 32 bits: increments on every pop.
  - stall_cnt_o, 32 bits: increments each cycle where out_valid_o=1 and out_ready_i=0.
- Counter behaviour:
  - Both reset to 0 asynchronously.
  - Both wrap at 2^32.
  - Flush does not clear them.
- When not defined: the ports and counters are absent and there is no logic change elsewhere.

Decomposition:
- Shared constants package (constants.svh) holds:
  - IMEM_BASE_ADDR and INSN_NOP;
  - RV32I opcode localparams;
  - a typedef struct for a queue entry {pc, insn}.
- One natural sub-module: decode_illegal_chk, a combinational legality checker taking insn and returning illegal.
- igen is reused as-is.

Test Plan:
- Reset release, idle:
  - After rst_n low->high: out_valid_o=0, in_ready_o=1, insn_o=0x00000013, count_o=0.
- Fill with no consumption (DEPTH=2, out_ready_i=0):
  - Push pc 0x01000000 insn 0x00500093 (addi x1,x0,5), then pc 0x01000004 insn 0x00A00113.
  - Expect count_o=2 and in_ready_o=0; the third offer is not accepted.
  - Head shows rd_o=1, imm_o=5.
- Full with simultaneous pop:
  - Assert out_ready_i with the queue full and in_valid_i held.
  - Expect a pop and no push that cycle; the push lands next cycle; the order of pcs out is 0x01000000, 0x01000004, 0x01000008.
- Flush with simultaneous push and pop:
  - Queue holds 2 entries; assert flush_i, in_valid_i and out_ready_i together.
  - Expect next cycle count_o=0, out_valid_o=0, and no entry from that cycle ever emerges.
- Illegal detection:
  - Push 0x40001033 (funct7=0100000, funct3=001, OP) -> illegal_o=1.
  - Push 0x40000033 (sub) -> illegal_o=0.
  - Push 0xFFFFFFFF -> illegal_o=1.
- Async reset mid-stream:
  - Drop rst_n between clock edges with 1 entry queued.
  - Expect out_valid_o=0 immediately and count_o=0.
  - With DECODE_QUEUE_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared constants for the decode queue: reset values, RV32I opcodes and the queue entry type.
package decode_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] IMEM_BASE_ADDR = 32'h0100_0000;
    localparam logic [XLEN-1:0] INSN_NOP       = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } entry_t;

endpackage

// File: rtl/decode_illegal_chk.sv
// Combinational RV32I legality check on opcode/funct3/funct7 of one instruction.
module decode_illegal_chk
    import decode_queue_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedBits;

    assign opcode     = insn_i[6:0];
    assign funct3     = insn_i[14:12];
    assign funct7     = insn_i[31:25];
    assign unusedBits = ^{insn_i[24:15], insn_i[11:7]};

    always_comb begin
        illegal_o = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM:
                illegal_o = 1'b0;
            OPC_JALR:
                illegal_o = (funct3 != 3'b000);
            OPC_BRANCH:
                illegal_o = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_LOAD:
                illegal_o = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OPC_STORE:
                illegal_o = (funct3 > 3'b010);
            OPC_OP:
                illegal_o = ((funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT))
                         || ((funct7 == FUNCT7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
            OPC_OP_IMM:
                // Only the shift encodings constrain the upper bits.
                illegal_o = ((funct3 == 3'b001) && (funct7 != FUNCT7_ZERO))
                         || ((funct3 == 3'b101) && (funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT));
            default:
                illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/igen.sv
// RV32I immediate generator: sign-extended immediate selected by the instruction format.
module igen
    import decode_queue_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (insn_i[6:0])
            OPC_LUI, OPC_AUIPC:
                imm_o = {insn_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:
                imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
            OPC_STORE:
                imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OPC_BRANCH:
                imm_o = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// DEPTH-entry fetch->execute instruction queue with RV32I decode of the head entry.
// Defining DECODE_QUEUE_PERF_EN adds decoded/stall event counters.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [AWIDTH-1:0]          pc_i,
    input  logic [DWIDTH-1:0]          insn_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [6:0]                 opcode_o,
    output logic [4:0]                 rd_o,
    output logic [2:0]                 funct3_o,
    output logic [4:0]                 rs1_o,
    output logic [4:0]                 rs2_o,
    output logic [4:0]                 shamt_o,
    output logic [6:0]                 funct7_o,
    output logic [DWIDTH-1:0]          imm_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]                decoded_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          slots_q [DEPTH];
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic            headIllegal;
    entry_t          head;

    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = wrPtr_q;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PW'(1);
            if (pop)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '{pc: IMEM_BASE_ADDR, insn: INSN_NOP};
            end
        end else if (push) begin
            slots_q[wrPtr_q] <= '{pc: pc_i, insn: insn_i};
        end
    end

    // An empty queue presents a NOP so downstream decode never sees stale bits.
    assign head     = slots_q[rdPtr_q];
    assign pc_o     = head.pc;
    assign insn_o   = out_valid_o ? head.insn : INSN_NOP;
    assign opcode_o = insn_o[6:0];
    assign rd_o     = insn_o[11:7];
    assign funct3_o = insn_o[14:12];
    assign rs1_o    = insn_o[19:15];
    assign rs2_o    = insn_o[24:20];
    assign shamt_o  = insn_o[24:20];
    assign funct7_o = insn_o[31:25];
    assign count_o  = count_q;

    igen u_igen (
        .insn_i (insn_o),
        .imm_o  (imm_o)
    );

    decode_illegal_chk u_illegal_chk (
        .insn_i    (insn_o),
        .illegal_o (headIllegal)
    );

    assign illegal_o = headIllegal & out_valid_o;

`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] decodedCnt_q;
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decodedCnt_q <= '0;
            stallCnt_q   <= '0;
        end else begin
            if (pop)                         decodedCnt_q <= decodedCnt_q + 32'd1;
            if (out_valid_o && !out_ready_i) stallCnt_q   <= stallCnt_q + 32'd1;
        end
    end

    assign decoded_cnt_o = decodedCnt_q;
    assign stall_cnt_o   = stallCnt_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic against a queue model.
module tb_decode_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [31:0]   pcIn;
    logic [31:0]   insnIn;
    logic          outValid;
    logic          outReady;
    logic [31:0]   pcOut;
    logic [31:0]   insnOut;
    logic [6:0]    opcodeOut;
    logic [4:0]    rdOut;
    logic [2:0]    funct3Out;
    logic [4:0]    rs1Out;
    logic [4:0]    rs2Out;
    logic [4:0]    shamtOut;
    logic [6:0]    funct7Out;
    logic [31:0]   immOut;
    logic          illegalOut;
    logic [CW-1:0] countOut;
`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0]   decodedCnt;
    logic [31:0]   stallCnt;
    logic [31:0]   refDecoded;
    logic [31:0]   refStall;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ref_entry_t;

    ref_entry_t  mq[$];
    logic [31:0] dutPopped[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    decode_queue #(.DWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .pc_i        (pcIn),
        .insn_i      (insnIn),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .pc_o        (pcOut),
        .insn_o      (insnOut),
        .opcode_o    (opcodeOut),
        .rd_o        (rdOut),
        .funct3_o    (funct3Out),
        .rs1_o       (rs1Out),
        .rs2_o       (rs2Out),
        .shamt_o     (shamtOut),
        .funct7_o    (funct7Out),
        .imm_o       (immOut),
        .illegal_o   (illegalOut),
        .count_o     (countOut)
`ifdef DECODE_QUEUE_PERF_EN
        ,
        .decoded_cnt_o (decodedCnt),
        .stall_cnt_o   (stallCnt)
`endif
    );

    // Immediate value written from the ISA's field placement using integer arithmetic.
    function automatic logic [31:0] refImm(input logic [31:0] x);
        int v;
        v = 0;
        case (int'(x[6:0]))
            'h37, 'h17: v = int'(x & 32'hFFFF_F000);
            'h6F: v = (x[31] ? -1048576 : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048
                    + int'(x[30:21]) * 2;
            'h67, 'h03, 'h13: v = $signed(x) >>> 20;
            'h23: v = ($signed(x) >>> 25) * 32 + int'(x[11:7]);
            'h63: v = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32
                    + int'(x[11:8]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic refIllegal(input logic [31:0] x);
        int op, f3, f7;
        op = int'(x[6:0]);
        f3 = int'(x[14:12]);
        f7 = int'(x[31:25]);
        case (op)
            'h37, 'h17, 'h6F, 'h0F, 'h73: return 1'b0;
            'h67: return f3 != 0;
            'h63: return (f3 == 2) || (f3 == 3);
            'h03: return (f3 == 3) || (f3 >= 6);
            'h23: return f3 > 2;
            'h33: return !((f7 == 0) || (f7 == 32)) || ((f7 == 32) && (f3 != 0) && (f3 != 5));
            'h13: return ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && (f7 != 0) && (f7 != 32));
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic        expValid;
        logic [31:0] expInsn;
        expValid = (mq.size() != 0);
        expInsn  = expValid ? mq[0].insn : 32'h0000_0013;
        chk({tag, "_valid"}, 32'(outValid), 32'(expValid));
        chk({tag, "_ready"}, 32'(inReady), 32'(mq.size() != DEPTH));
        chk({tag, "_count"}, 32'(countOut), 32'(mq.size()));
        chk({tag, "_insn"}, insnOut, expInsn);
        chk({tag, "_fields"}, {funct7Out, rs2Out, rs1Out, funct3Out, rdOut, opcodeOut}, expInsn);
        chk({tag, "_shamt"}, 32'(shamtOut), 32'(expInsn[24:20]));
        chk({tag, "_imm"}, immOut, refImm(expInsn));
        chk({tag, "_illegal"}, 32'(illegalOut), 32'(expValid && refIllegal(expInsn)));
        if (expValid) chk({tag, "_pc"}, pcOut, mq[0].pc);
`ifdef DECODE_QUEUE_PERF_EN
        chk({tag, "_decoded_cnt"}, decodedCnt, refDecoded);
        chk({tag, "_stall_cnt"}, stallCnt, refStall);
`endif
    endtask

    // Called at a falling edge: drive inputs, advance one clock, update the model, check.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                                 input logic rdy, input logic fl, input string tag);
        logic doPush, doPop, wasValid;
        inValid  = v;
        pcIn     = pc;
        insnIn   = insn;
        outReady = rdy;
        flush    = fl;
        #1;
        if (outValid && outReady && !flush) dutPopped.push_back(pcOut);
        @(posedge clk);
        wasValid = (mq.size() != 0);
        doPush   = inValid && (mq.size() < DEPTH) && !flush;
        doPop    = outReady && wasValid && !flush;
`ifdef DECODE_QUEUE_PERF_EN
        if (doPop) refDecoded = refDecoded + 32'd1;
        if (wasValid && !outReady) refStall = refStall + 32'd1;
`endif
        if (flush) begin
            mq.delete();
        end else begin
            if (doPop)  void'(mq.pop_front());
            if (doPush) mq.push_back('{pc: pc, insn: insn});
        end
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0]  opcs [11];
        logic [31:0] illegalInsn [3];
        logic [31:0] illegalExp [3];
        logic [31:0] orderExp [3];
        logic [31:0] r;
        logic [31:0] pcNext;

        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        illegalInsn = '{32'h4000_1033, 32'h4000_0033, 32'hFFFF_FFFF};
        illegalExp  = '{32'd1, 32'd0, 32'd1};
        orderExp    = '{32'h0100_0000, 32'h0100_0004, 32'h0100_0008};
`ifdef DECODE_QUEUE_PERF_EN
        refDecoded = '0;
        refStall   = '0;
`endif

        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        pcIn = '0; insnIn = '0;
        @(negedge clk);
        chk("in_reset_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_insn", insnOut, 32'h0000_0013);
        chk("reset_pc", pcOut, 32'h0100_0000);
        chk("reset_imm", immOut, 32'd0);
        chk("reset_count", 32'(countOut), 32'd0);
        chk("reset_ready", 32'(inReady), 32'd1);
        checkOutput("reset");

        // Fill with no consumption; third offer must be refused.
        applyStimulus(1'b1, 32'h0100_0000, 32'h0050_0093, 1'b0, 1'b0, "fill0");
        applyStimulus(1'b1, 32'h0100_0004, 32'h00A0_0113, 1'b0, 1'b0, "fill1");
        chk("fill_count", 32'(countOut), 32'd2);
        chk("fill_ready", 32'(inReady), 32'd0);
        chk("fill_rd", 32'(rdOut), 32'd1);
        chk("fill_imm", immOut, 32'd5);
        applyStimulus(1'b1, 32'h0100_0008, 32'h00C0_0193, 1'b0, 1'b0, "fill2");
        chk("fill_refused_count", 32'(countOut), 32'd2);

        // Full with simultaneous pop: pop only, push lands the cycle after.
        dutPopped.delete();
        applyStimulus(1'b1, 32'h0100_0008, 32'h00C0_0193, 1'b1, 1'b0, "fullpop0");
        chk("fullpop_count", 32'(countOut), 32'd1);
        applyStimulus(1'b1, 32'h0100_0008, 32'h00C0_0193, 1'b1, 1'b0, "fullpop1");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fullpop2");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fullpop3");
        chk("order_len", 32'(dutPopped.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < dutPopped.size()) chk($sformatf("order_pc%0d", i), dutPopped[i], orderExp[i]);
        end

        // Flush with simultaneous push and pop on a full queue.
        applyStimulus(1'b1, 32'h0100_000C, 32'h0010_0093, 1'b0, 1'b0, "flfill0");
        applyStimulus(1'b1, 32'h0100_0010, 32'h0020_0113, 1'b0, 1'b0, "flfill1");
        applyStimulus(1'b1, 32'h0100_0014, 32'h0030_0193, 1'b1, 1'b1, "flush");
        chk("flush_count", 32'(countOut), 32'd0);
        chk("flush_valid", 32'(outValid), 32'd0);
        dutPopped.delete();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "postflush0");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "postflush1");
        chk("flush_nothing_emerges", 32'(dutPopped.size()), 32'd0);
        applyStimulus(1'b1, 32'h0100_0018, 32'h0040_0213, 1'b0, 1'b0, "postflush2");
        chk("postflush_pc", pcOut, 32'h0100_0018);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "postflush3");

        // Illegal-instruction spot checks.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0100_0100 + 32'(4*i), illegalInsn[i], 1'b0, 1'b0, "illpush");
            chk($sformatf("illegal%0d", i), 32'(illegalOut), illegalExp[i]);
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "illpop");
        end

        // Random traffic, mostly well-formed opcodes, occasional flush.
        pcNext = 32'h0100_1000;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(3) != 0) r[6:0] = opcs[$urandom_range(10)];
            applyStimulus(1'($urandom_range(1)), pcNext, r, 1'($urandom_range(1)),
                          ($urandom_range(15) == 0), "rand");
            pcNext = pcNext + 32'd4;
        end

        // Async reset mid-stream with one entry queued.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain0");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain1");
        applyStimulus(1'b1, 32'h0100_2000, 32'h0050_0093, 1'b0, 1'b0, "arpush");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "arhold");
        chk("ar_pre_count", 32'(countOut), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(outValid), 32'd0);
        chk("ar_count", 32'(countOut), 32'd0);
        chk("ar_ready", 32'(inReady), 32'd1);
        chk("ar_insn", insnOut, 32'h0000_0013);
`ifdef DECODE_QUEUE_PERF_EN
        chk("ar_decoded_cnt", decodedCnt, 32'd0);
        chk("ar_stall_cnt", stallCnt, 32'd0);
        refDecoded = '0;
        refStall   = '0;
`endif
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ar_release");
        applyStimulus(1'b1, 32'h0100_3000, 32'h0010_0093, 1'b0, 1'b0, "arrecover0");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "arrecover1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
